// File: rtl/jedro_1_lsu_if.sv
// jedro_1 LSU bus bundle: execute-stage request, data RAM port and write-back result.
// slave = the LSU itself, master = the surrounding pipeline/RAM.
interface jedro_1_lsu_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_we_i;
  logic [2:0]                req_funct3_i;
  logic [ADDR_WIDTH-1:0]     req_addr_i;
  logic [DATA_WIDTH-1:0]     req_wdata_i;
  logic [REG_ADDR_WIDTH-1:0] req_rd_i;
  logic                      mem_en_o;
  logic [3:0]                mem_we_o;
  logic [ADDR_WIDTH-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;
  logic                      wb_valid_o;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_o;
  logic [DATA_WIDTH-1:0]     wb_data_o;
  logic                      st_done_o;
  logic                      misaligned_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i, mem_rdata_i,
    output req_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           wb_valid_o, wb_rd_o, wb_data_o, st_done_o, misaligned_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i, mem_rdata_i,
    input  req_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           wb_valid_o, wb_rd_o, wb_data_o, st_done_o, misaligned_o
  );
endinterface

// File: rtl/jedro_1_lsu.sv
// jedro_1 load/store unit: one op at a time, IDLE -> ACCESS (-> WAIT for loads).
// Optional macro JEDRO_1_LSU_MISALIGN_TRAP_EN drops misaligned ops instead of aligning them.
module jedro_1_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  jedro_1_lsu_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

  state_t                    r_state;
  logic                      r_we;
  logic [2:0]                r_funct3;
  logic [1:0]                r_lane;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_mem_en;
  logic [3:0]                r_mem_we;
  logic [ADDR_WIDTH-1:0]     r_mem_addr;
  logic [DATA_WIDTH-1:0]     r_mem_wdata;
  logic                      r_wb_valid;
  logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0]     r_wb_data;
  logic                      r_st_done;
  logic                      r_misaligned;

  logic                  w_is_byte;
  logic                  w_is_half;
  logic                  w_trap;
  logic [1:0]            w_lane;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [7:0]            w_rbyte;
  logic [15:0]           w_rhalf;
  logic [DATA_WIDTH-1:0] w_load;

  // Unlisted encodings and stores with funct3[2] set fall through to word size.
  always_comb begin
    w_is_byte = (bus.req_funct3_i == 3'b000) || (!bus.req_we_i && bus.req_funct3_i == 3'b100);
    w_is_half = (bus.req_funct3_i == 3'b001) || (!bus.req_we_i && bus.req_funct3_i == 3'b101);
    w_lane    = 2'b00;
    w_be      = 4'b1111;
    w_wdata   = bus.req_wdata_i;
    if (w_is_byte) begin
      w_lane  = bus.req_addr_i[1:0];
      w_be    = 4'b0001 << w_lane;
      w_wdata = {4{bus.req_wdata_i[7:0]}};
    end else if (w_is_half) begin
      w_lane  = {bus.req_addr_i[1], 1'b0};
      w_be    = 4'b0011 << w_lane;
      w_wdata = {2{bus.req_wdata_i[15:0]}};
    end
  end

`ifdef JEDRO_1_LSU_MISALIGN_TRAP_EN
  assign w_trap = w_is_half ? bus.req_addr_i[0] : (!w_is_byte && (bus.req_addr_i[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_rbyte = bus.mem_rdata_i[{r_lane, 3'b000} +: 8];
    w_rhalf = r_lane[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_rbyte[7]}}, w_rbyte};
      3'b100:  w_load = {24'h0, w_rbyte};
      3'b001:  w_load = {{16{w_rhalf[15]}}, w_rhalf};
      3'b101:  w_load = {16'h0, w_rhalf};
      default: w_load = bus.mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_lane       <= 2'b00;
      r_rd         <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 4'b0000;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_st_done    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_st_done    <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_we     <= bus.req_we_i;
            r_funct3 <= bus.req_funct3_i;
            r_lane   <= w_lane;
            r_rd     <= bus.req_rd_i;
            if (w_trap) begin
              r_misaligned <= 1'b1;
            end else begin
              r_state     <= S_ACCESS;
              r_mem_en    <= 1'b1;
              r_mem_we    <= bus.req_we_i ? w_be : 4'b0000;
              r_mem_addr  <= {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
              r_mem_wdata <= w_wdata;
            end
          end
        end
        S_ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 4'b0000;
          if (r_we) begin
            r_st_done <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          r_wb_data  <= w_load;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready is gated by reset so it reads 0 for the whole time rst_i is high.
  assign bus.req_ready_o  = (r_state == S_IDLE) && !rst_i;
  assign bus.mem_en_o     = r_mem_en;
  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_wdata_o  = r_mem_wdata;
  assign bus.wb_valid_o   = r_wb_valid;
  assign bus.wb_rd_o      = r_wb_rd;
  assign bus.wb_data_o    = r_wb_data;
  assign bus.st_done_o    = r_st_done;
  assign bus.misaligned_o = r_misaligned;

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Directed bench for jedro_1_lsu: vector table of loads/stores against a small byte-write RAM,
// plus hand sequences for back-to-back issue, misaligned word load and reset mid-access.
module tb_jedro_1_lsu;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  jedro_1_lsu_if bus ();

  jedro_1_lsu dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read data one cycle after mem_en_o, byte-lane writes.
  logic [31:0] ram [0:3];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin : ram_blk
    logic [31:0] nw;
    if (!ram_loaded) begin
      ram[0]     <= 32'hFFFF000F;
      ram[1]     <= 32'h0000_0000;
      ram[2]     <= 32'h0000_0000;
      ram[3]     <= 32'h0000_0000;
      ram_loaded <= 1'b1;
    end else if (bus.mem_en_o) begin
      nw = ram[bus.mem_addr_o[3:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_o[b]) nw[8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
      ram[bus.mem_addr_o[3:2]] <= nw;
      bus.mem_rdata_i          <= ram[bus.mem_addr_o[3:2]];
    end
  end

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    bus.req_rd_i     = rd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.we, v.f3, v.addr, v.wdata, v.rd);
    check($sformatf("v%0d ready", idx), {31'h0, bus.req_ready_o}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check($sformatf("v%0d mem_en", idx), {31'h0, bus.mem_en_o}, 32'h1);
    check($sformatf("v%0d mem_addr", idx), bus.mem_addr_o, v.exp_maddr);
    check($sformatf("v%0d mem_we", idx), {28'h0, bus.mem_we_o}, {28'h0, v.exp_be});
    if (v.we) check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata_o, v.exp_wdata);
    @(posedge clk); #1;
    check($sformatf("v%0d mem_en_off", idx), {31'h0, bus.mem_en_o}, 32'h0);
    if (v.we) begin
      check($sformatf("v%0d st_done", idx), {31'h0, bus.st_done_o}, 32'h1);
    end else begin
      check($sformatf("v%0d wb_early", idx), {31'h0, bus.wb_valid_o}, 32'h0);
      @(posedge clk); #1;
      check($sformatf("v%0d wb_valid", idx), {31'h0, bus.wb_valid_o}, 32'h1);
      check($sformatf("v%0d wb_rd", idx), {27'h0, bus.wb_rd_o}, {27'h0, v.rd});
      check($sformatf("v%0d wb_data", idx), bus.wb_data_o, v.exp_data);
    end
  endtask

  initial begin
    //            we    f3      addr          wdata         rd     exp_data      be       maddr  exp_wdata
    vecs[0]  = '{1'b0, 3'b001, 32'h0, 32'h0,        5'd30, 32'hFFFFFFFF, 4'b0000, 32'h0, 32'h0} ;
    vecs[0].addr = 32'h2;
    vecs[1]  = '{1'b0, 3'b001, 32'h0, 32'h0,        5'd14, 32'h0000000F, 4'b0000, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 3'b101, 32'h2, 32'h0,        5'd3,  32'h0000FFFF, 4'b0000, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 3'b100, 32'h3, 32'h0,        5'd4,  32'h000000FF, 4'b0000, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 3'b000, 32'h3, 32'h0,        5'd5,  32'hFFFFFFFF, 4'b0000, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 3'b000, 32'h0, 32'h0,        5'd6,  32'h0000000F, 4'b0000, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 3'b000, 32'h7, 32'h123456AB, 5'd0,  32'h0,        4'b1000, 32'h4, 32'hABABABAB};
    vecs[7]  = '{1'b0, 3'b010, 32'h4, 32'h0,        5'd7,  32'hAB000000, 4'b0000, 32'h4, 32'h0};
    vecs[8]  = '{1'b1, 3'b001, 32'h4, 32'h0000BEEF, 5'd0,  32'h0,        4'b0011, 32'h4, 32'hBEEFBEEF};
    vecs[9]  = '{1'b0, 3'b001, 32'h4, 32'h0,        5'd8,  32'hFFFFBEEF, 4'b0000, 32'h4, 32'h0};
    vecs[10] = '{1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 5'd0,  32'h0,        4'b1111, 32'h8, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 3'b100, 32'h9, 32'h0,        5'd9,  32'h000000BE, 4'b0000, 32'h8, 32'h0};
    vecs[12] = '{1'b0, 3'b010, 32'h8, 32'h0,        5'd10, 32'hDEADBEEF, 4'b0000, 32'h8, 32'h0};
    vecs[13] = '{1'b0, 3'b000, 32'hA, 32'h0,        5'd11, 32'hFFFFFFAD, 4'b0000, 32'h8, 32'h0};

    rst = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;
    bus.req_rd_i     = 5'd0;
    #2;
    check("rst ready", {31'h0, bus.req_ready_o}, 32'h0);
    check("rst mem_en", {31'h0, bus.mem_en_o}, 32'h0);
    check("rst wb_valid", {31'h0, bus.wb_valid_o}, 32'h0);
    check("rst wb_data", bus.wb_data_o, 32'h0);
    check("rst misc", {bus.mem_we_o, bus.st_done_o, bus.misaligned_o, bus.wb_rd_o}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst ready", {31'h0, bus.req_ready_o}, 32'h1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Back-to-back: second LW accepted in the cycle the first result is presented.
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h0, 32'h0, 5'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b2b wb_valid1", {31'h0, bus.wb_valid_o}, 32'h1);
    check("b2b ready", {31'h0, bus.req_ready_o}, 32'h1);
    check("b2b data1", bus.wb_data_o, 32'hFFFF000F);
    check("b2b rd1", {27'h0, bus.wb_rd_o}, 32'd1);
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h8, 32'h0, 5'd2);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("b2b mem_en2", {31'h0, bus.mem_en_o}, 32'h1);
    check("b2b wb_off", {31'h0, bus.wb_valid_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("b2b wb_valid2", {31'h0, bus.wb_valid_o}, 32'h1);
    check("b2b data2", bus.wb_data_o, 32'hDEADBEEF);
    check("b2b rd2", {27'h0, bus.wb_rd_o}, 32'd2);

    // Misaligned LW at 0x1.
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h1, 32'h0, 5'd12);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
`ifdef JEDRO_1_LSU_MISALIGN_TRAP_EN
    check("mis pulse", {31'h0, bus.misaligned_o}, 32'h1);
    check("mis mem_en", {31'h0, bus.mem_en_o}, 32'h0);
    check("mis ready", {31'h0, bus.req_ready_o}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("mis quiet%0d", c),
            {29'h0, bus.mem_en_o, bus.wb_valid_o, bus.misaligned_o}, 32'h0);
    end
`else
    check("mis mem_en", {31'h0, bus.mem_en_o}, 32'h1);
    check("mis mem_addr", bus.mem_addr_o, 32'h0);
    check("mis flag", {31'h0, bus.misaligned_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("mis wb_valid", {31'h0, bus.wb_valid_o}, 32'h1);
    check("mis wb_data", bus.wb_data_o, 32'hFFFF000F);
`endif

    // Reset while in WAIT: no result, everything cleared at once.
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h0, 32'h0, 5'd7);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw ready", {31'h0, bus.req_ready_o}, 32'h0);
    check("rstw wb_data", bus.wb_data_o, 32'h0);
    check("rstw strobes", {27'h0, bus.mem_en_o, bus.mem_we_o}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstw no_wb%0d", c), {31'h0, bus.wb_valid_o}, 32'h0);
    end

    // Reset while in ACCESS: strobe drops without waiting for a clock.
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h8, 32'h0, 5'd9);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("rsta mem_en_pre", {31'h0, bus.mem_en_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("rsta mem_en", {31'h0, bus.mem_en_o}, 32'h0);
    check("rsta mem_addr", bus.mem_addr_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("rsta no_wb%0d", c), {31'h0, bus.wb_valid_o}, 32'h0);
    end

    // Normal load after the resets.
    run_vec(vecs[12], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/jedro_1_lsu.md
Name: jedro_1_lsu

Overview:
Load/store unit of the jedro_1 core. It sits between the execute stage and the register-file write-back. It accepts one decoded memory op at a time, drives the byte-write data RAM port with word-aligned address, byte enables and lane-shifted store data, and returns sign- or zero-extended load results (LB/LH/LW/LBU/LHU) to write-back. It issues at most one access per op, and a new op is accepted only when no access is outstanding.

Parameters:
DATA_WIDTH, 32, data bus and register width (fixed at 32; other values unsupported)
ADDR_WIDTH, 32, byte address width
REG_ADDR_WIDTH, 5, destination register index width

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  1  execute stage presents an op
req_ready_o  out  1  LSU can accept an op this cycle
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr_i  in  ADDR_WIDTH  byte address (already computed rs1+imm)
req_wdata_i  in  DATA_WIDTH  store data (rs2)
req_rd_i  in  REG_ADDR_WIDTH  load destination register
mem_en_o  out  1  RAM access strobe
mem_we_o  out  4  byte write enables (0000 for loads)
mem_addr_o  out  ADDR_WIDTH  word-aligned address (low 2 bits 0)
mem_wdata_o  out  DATA_WIDTH  lane-aligned store data
mem_rdata_i  in  DATA_WIDTH  RAM read data, valid exactly 1 cycle after mem_en_o
wb_valid_o  out  1  one-cycle pulse: load result valid
wb_rd_o  out  REG_ADDR_WIDTH  destination register
wb_data_o  out  DATA_WIDTH  extended load result
st_done_o  out  1  one-cycle pulse: store issued
misaligned_o  out  1  one-cycle pulse: misaligned op dropped (feature-dependent)

Behaviour:
- Reset: all outputs 0, including req_ready_o while rst_i is high. The FSM goes to IDLE; any in-flight access is abandoned with no wb_valid_o or st_done_o.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE: req_ready_o=1. On req_valid_i, the op is registered (we, funct3, addr, wdata, rd) and the FSM goes to ACCESS. If the op is misaligned and trapping is enabled, it goes to IDLE instead and misaligned_o pulses in the next cycle.
- ACCESS: mem_en_o=1 and mem_addr_o={addr[31:2],2'b00}, all driven from registers.
  - Store: mem_we_o = SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111. mem_wdata_o = wdata replicated per width (byte x4, half x2). st_done_o pulses in the following cycle. Next state IDLE.
  - Load: mem_we_o=0000. Next state WAIT.
- WAIT: select lane from mem_rdata_i by addr[1:0] (byte) or addr[1] (half). Sign-extend for 000/001, zero-extend for 100/101; word passes through. The result is registered into wb_data_o with wb_rd_o, and wb_valid_o=1 in the next cycle. Next state IDLE.
- Latency: op accepted at edge N. mem_en_o is high in cycle N+1. Load wb_valid_o is high in cycle N+3. Store st_done_o is high in cycle N+2.
- Throughput: one op every 3 cycles for loads, every 2 cycles for stores. An op may be accepted in the same cycle that wb_valid_o or st_done_o is high.
- funct3 encodings 011/110/111, and stores with funct3[2]=1, are treated as W. The decoder guarantees these never occur.
- wb_data_o and wb_rd_o hold their last value between pulses. mem_we_o and mem_en_o are 0 outside ACCESS.
- Reset asserted in ACCESS or WAIT: RAM strobes drop immediately (asynchronous) and no result is produced.

Optional Feature:
JEDRO_1_LSU_MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is not issued to RAM. misaligned_o pulses 1 cycle after acceptance, and there is no wb_valid_o or st_done_o.
- Undefined: misaligned_o is tied 0. Low address bits are forced aligned (half clears addr[0], word clears addr[1:0]) and the access proceeds normally.

Test Plan:
- RAM word @0x0 = 0xFFFF000F; LH addr 0x2, rd=30 -> wb_valid_o in cycle N+3, wb_rd_o=30, wb_data_o=0xFFFFFFFF.
- Same word; LH addr 0x0, rd=14 -> 0x0000000F. LHU addr 0x2 -> 0x0000FFFF. LBU addr 0x3 -> 0x000000FF. LB addr 0x3 -> 0xFFFFFFFF.
- SB wdata 0x123456AB addr 0x7 -> in cycle N+1: mem_we_o=1000, mem_addr_o=0x4, mem_wdata_o=0xABABABAB. Subsequent LW 0x4 returns byte3=0xAB.
- Back-to-back: LW accepted in the same cycle as the previous wb_valid_o -> req_ready_o stays 1 and both results are correct.
- LW addr 0x1: with JEDRO_1_LSU_MISALIGN_TRAP_EN -> misaligned_o pulse, mem_en_o never high. Without it -> read of word @0x0 is returned.
- rst_i asserted during WAIT -> wb_valid_o stays 0, all outputs 0 immediately. After release, a new LW completes normally.
